// File: rtl/accum_mc.sv
// rtl/accum_mc.sv - multi-channel signed accumulator with saturation and read-and-clear dump
//
// Purpose: NUM_CH independent signed accumulators sharing a single sample input.
//   A dump reads one channel into a held result register and reloads that channel
//   in the same cycle. The result is offered with a valid/ready handshake.
//
// Ports:
//   clk            in   sole clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   en_i           in   accumulate data_i into channel ch_i
//   clear_i        in   zero channel ch_i and its overflow flag (top priority)
//   dump_i         in   read-and-clear request for channel ch_i
//   ch_i           in   channel select; values >= NUM_CH are ignored
//   data_i         in   signed sample, DIN_WIDTH bits
//   result_o       out  dumped accumulator value, DOUT_WIDTH bits signed
//   result_ch_o    out  channel of result_o
//   result_ovf_o   out  sticky overflow flag of the dumped channel
//   result_valid_o out  result fields valid; held until result_ready_i
//   result_ready_i in   downstream accepts the result
//   busy_o         out  result pending and not being taken; dumps are dropped
//   ovf_o          out  per-channel sticky overflow flags

module accum_mc #(
  parameter  int DIN_WIDTH  = 32,
  parameter  int DOUT_WIDTH = 40,
  parameter  int NUM_CH     = 4,
  parameter  int SAT_EN     = 1,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic                         clear_i,
  input  logic                         dump_i,
  input  logic [CH_W-1:0]              ch_i,
  input  logic signed [DIN_WIDTH-1:0]  data_i,
  output logic signed [DOUT_WIDTH-1:0] result_o,
  output logic [CH_W-1:0]              result_ch_o,
  output logic                         result_ovf_o,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic                         busy_o,
  output logic [NUM_CH-1:0]            ovf_o
);

  localparam logic signed [DOUT_WIDTH-1:0] POS_MAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] NEG_MAX = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  logic signed [DOUT_WIDTH-1:0] acc_q [NUM_CH];
  logic signed [DOUT_WIDTH-1:0] acc_d [NUM_CH];
  logic [NUM_CH-1:0]            ovf_q, ovf_d;

  logic signed [DOUT_WIDTH-1:0] res_q, res_d;
  logic [CH_W-1:0]              rch_q, rch_d;
  logic                         rovf_q, rovf_d;
  logic                         valid_q, valid_d;

  logic                         ch_ok;
  logic [CH_W-1:0]              ch_idx;
  logic                         busy;
  logic                         dump_ok;
  logic signed [DOUT_WIDTH-1:0] ext;
  logic signed [DOUT_WIDTH:0]   sum;
  logic                         sum_ovf;
  logic signed [DOUT_WIDTH-1:0] acc_new;

  // Out-of-range channels turn every command into a no-op; the index is
  // forced to 0 so array reads stay in bounds, and ch_ok gates all writes.
  assign ch_ok   = (32'(ch_i) < NUM_CH);
  assign ch_idx  = ch_ok ? ch_i : '0;
  assign busy    = valid_q & ~result_ready_i;
  assign dump_ok = dump_i & ~clear_i & ~busy & ch_ok;

  // One guard bit above the accumulator width: overflow shows up as the two
  // top bits of the sum disagreeing, and the guard bit gives the direction.
  assign ext     = DOUT_WIDTH'(data_i);
  assign sum     = (DOUT_WIDTH+1)'(acc_q[ch_idx]) + (DOUT_WIDTH+1)'(ext);
  assign sum_ovf = sum[DOUT_WIDTH] ^ sum[DOUT_WIDTH-1];

  always_comb begin
    acc_new = sum[DOUT_WIDTH-1:0];
    if (sum_ovf && (SAT_EN != 0)) begin
      acc_new = sum[DOUT_WIDTH] ? NEG_MAX : POS_MAX;
    end
  end

  always_comb begin
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    rch_d   = rch_q;
    rovf_d  = rovf_q;
    valid_d = valid_q & ~result_ready_i;

    if (ch_ok) begin
      if (clear_i) begin
        acc_d[ch_idx] = '0;
        ovf_d[ch_idx] = 1'b0;
      end else if (dump_ok) begin
        // Read-and-clear: the result takes the pre-update value, and a
        // coincident sample starts the fresh accumulation.
        acc_d[ch_idx] = en_i ? ext : '0;
        ovf_d[ch_idx] = 1'b0;
      end else if (en_i) begin
        acc_d[ch_idx] = acc_new;
        if (sum_ovf) begin
          ovf_d[ch_idx] = 1'b1;
        end
      end
    end

    if (dump_ok) begin
      res_d   = acc_q[ch_idx];
      rch_d   = ch_i;
      rovf_d  = ovf_q[ch_idx];
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
      end
      ovf_q   <= '0;
      res_q   <= '0;
      rch_q   <= '0;
      rovf_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      rch_q   <= rch_d;
      rovf_q  <= rovf_d;
      valid_q <= valid_d;
    end
  end

  assign result_o       = res_q;
  assign result_ch_o    = rch_q;
  assign result_ovf_o   = rovf_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy;
  assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_accum_mc.sv
// tb/tb_accum_mc.sv - scoreboard bench for accum_mc, saturating and wrapping instances

module tb_accum_mc;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, clr, dmp, rdy;
  logic [2:0]        ch;
  logic signed [7:0] din;

  logic signed [9:0] r_s, r_w;
  logic [2:0]        rch_s, rch_w;
  logic              rovf_s, rovf_w, rv_s, rv_w, busy_s, busy_w;
  logic [4:0]        ovf_s, ovf_w;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int ch;
    int vs;
    int vw;
    int ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  accum_mc #(.DIN_WIDTH(8), .DOUT_WIDTH(10), .NUM_CH(5), .SAT_EN(1)) dut_s (
    .clk(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .dump_i(dmp), .ch_i(ch),
    .data_i(din), .result_o(r_s), .result_ch_o(rch_s), .result_ovf_o(rovf_s),
    .result_valid_o(rv_s), .result_ready_i(rdy), .busy_o(busy_s), .ovf_o(ovf_s)
  );

  accum_mc #(.DIN_WIDTH(8), .DOUT_WIDTH(10), .NUM_CH(5), .SAT_EN(0)) dut_w (
    .clk(clk), .rst_i(rst), .en_i(en), .clear_i(clr), .dump_i(dmp), .ch_i(ch),
    .data_i(din), .result_o(r_w), .result_ch_o(rch_w), .result_ovf_o(rovf_w),
    .result_valid_o(rv_w), .result_ready_i(rdy), .busy_o(busy_w), .ovf_o(ovf_w)
  );

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input int vs, input int vw, input int o);
    exp_t e;
    e.ch = c; e.vs = vs; e.vw = vw; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic step(input logic e, input logic c, input logic d,
                      input logic [2:0] chn, input int dv);
    en = e; clr = c; dmp = d; ch = chn; din = 8'(dv);
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b0; dmp = 1'b0; din = '0;
  endtask

  // Monitor: a result is consumed on the edge after valid & ready is seen.
  always @(negedge clk) begin
    if (!rst && rv_s && rdy) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got ch %0d value %0d, expected none", rch_s, r_s);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_val_sat", int'(r_s), e.vs);
        chk("res_val_wrap", int'(r_w), e.vw);
        chk("res_ch", int'(rch_s), e.ch);
        chk("res_ovf_sat", int'(rovf_s), e.ovf);
        chk("res_ovf_wrap", int'(rovf_w), e.ovf);
        chk("res_valid_wrap", int'(rv_w), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; en = 1'b0; clr = 1'b0; dmp = 1'b0; ch = '0; din = '0;
    #3;
    chk("rst_valid", int'(rv_s), 0);
    chk("rst_result", int'(r_s), 0);
    chk("rst_ovf", int'(ovf_s), 0);
    #4 rst = 1'b0;
    @(posedge clk); #1;

    // Basic accumulate and read-and-clear
    step(1, 0, 0, 0, 5);
    step(1, 0, 0, 0, -3);
    step(1, 0, 0, 0, 10);
    push(0, 12, 12, 0);
    step(0, 0, 1, 0, 0);
    chk("dump_valid_next", int'(rv_s), 1);
    chk("dump_ch_next", int'(rch_s), 0);
    push(0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("valid_drop_after_hs", int'(rv_s), 0);

    // Positive overflow: 4 x 127 = 508 fits, fifth crosses 511
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 127);
    chk("no_ovf_at_508", int'(ovf_s[1]), 0);
    step(1, 0, 0, 1, 127);
    chk("ovf_sat_ch1", int'(ovf_s[1]), 1);
    chk("ovf_wrap_ch1", int'(ovf_w[1]), 1);
    push(1, 511, -389, 1);
    step(0, 0, 1, 1, 0);
    chk("ovf_clr_by_dump", int'(ovf_s[1]), 0);

    // Negative overflow: 5 x -128 = -640
    for (int i = 0; i < 5; i++) step(1, 0, 0, 3, -128);
    chk("ovf_neg_ch3", int'(ovf_s[3]), 1);
    push(3, -512, 384, 1);
    step(0, 0, 1, 3, 0);
    step(0, 0, 0, 0, 0);

    // Clear beats enable and dump
    step(1, 0, 0, 2, 7);
    step(1, 1, 1, 2, 5);
    chk("clear_no_valid", int'(rv_s), 0);
    step(1, 0, 0, 2, 9);
    push(2, 9, 9, 0);
    step(1, 0, 1, 2, 4);
    push(2, 4, 4, 0);
    step(0, 0, 1, 2, 0);
    step(0, 0, 0, 0, 0);

    // Backpressure: held result, dropped dump, continued accumulation
    step(1, 0, 0, 0, 3);
    rdy = 1'b0;
    push(0, 3, 3, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1, 0, 1, 1, 2);
      else        step(1, 0, 0, 1, 1);
      chk("stall_valid", int'(rv_s), 1);
      chk("stall_busy", int'(busy_s), 1);
      chk("stall_result", int'(r_s), 3);
      chk("stall_ch", int'(rch_s), 0);
    end
    rdy = 1'b1;
    push(1, 6, 6, 0);
    step(0, 0, 1, 1, 0);
    chk("b2b_valid", int'(rv_s), 1);
    chk("b2b_ch", int'(rch_s), 1);
    step(0, 0, 0, 0, 0);

    // Out-of-range channel is a no-op
    step(1, 0, 0, 4, 11);
    step(1, 0, 0, 5, 50);
    step(0, 1, 0, 5, 0);
    step(0, 0, 1, 5, 0);
    chk("oor_no_valid5", int'(rv_s), 0);
    step(1, 0, 1, 6, 40);
    chk("oor_no_valid6", int'(rv_s), 0);
    chk("oor_ovf", int'(ovf_s), 0);
    push(4, 11, 11, 0);
    step(0, 0, 1, 4, 0);
    step(0, 0, 0, 0, 0);

    // Asynchronous reset with a pending result and non-zero channels
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 127);
    step(1, 0, 0, 0, 20);
    rdy = 1'b0;
    push(0, 20, 20, 0);
    step(0, 0, 1, 0, 0);
    step(1, 0, 0, 2, 30);
    chk("pre_rst_valid", int'(rv_s), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", int'(rv_s), 0);
    chk("arst_result", int'(r_s), 0);
    chk("arst_ch", int'(rch_s), 0);
    chk("arst_rovf", int'(rovf_s), 0);
    chk("arst_ovf", int'(ovf_s), 0);
    chk("arst_busy", int'(busy_s), 0);
    void'(sb.pop_back());
    rst = 1'b0;
    rdy = 1'b1;
    push(2, 0, 0, 0);
    step(0, 0, 1, 2, 0);
    push(0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/accum_mc.md
ACCUM_MC -- requirements
Module: accum_mc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 32: signed input sample width.
REQ-002 SHALL have parameter DOUT_WIDTH, default 40: signed accumulator/result width, legal only when DOUT_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter NUM_CH, default 4: number of independent accumulator channels, legal range 1..256.
REQ-004 SHALL have parameter SAT_EN, default 1: 1 = saturate on overflow, 0 = two's-complement wrap.
REQ-005 SHALL define CH_W = max(1, clog2(NUM_CH)) as a derived local width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_i  in  1  reset, asynchronous and active-high.
REQ-008 en_i  in  1  accumulate data_i into channel ch_i.
REQ-009 clear_i  in  1  zero channel ch_i and its overflow flag.
REQ-010 dump_i  in  1  read-and-clear request for channel ch_i.
REQ-011 ch_i  in  CH_W  channel select for en_i/clear_i/dump_i.
REQ-012 data_i  in  DIN_WIDTH  signed sample.
REQ-013 result_o  out  DOUT_WIDTH  signed dumped accumulator value.
REQ-014 result_ch_o  out  CH_W  channel of result_o.
REQ-015 result_ovf_o  out  1  overflow flag of the dumped channel.
REQ-016 result_valid_o  out  1  result_o/result_ch_o/result_ovf_o valid.
REQ-017 result_ready_i  in  1  downstream accepts result.
REQ-018 busy_o  out  1  result_valid_o & ~result_ready_i; dump cannot be accepted.
REQ-019 ovf_o  out  NUM_CH  per-channel sticky overflow flags.

Function
REQ-020 data_i SHALL be sign-extended to DOUT_WIDTH before addition.
REQ-021 Sum SHALL be formed at DOUT_WIDTH+1 bits; overflow = the two top bits differ.
REQ-022 On overflow, SAT_EN=1 SHALL store +max (0x7F..F) for positive overflow and -max-1 (0x80..0) for negative; SAT_EN=0 SHALL store the low DOUT_WIDTH bits.
REQ-023 Any overflow SHALL set ovf_o[ch_i] on the same edge; it stays set until clear, dump or reset of that channel.
REQ-024 en_i alone SHALL update acc[ch_i] on the next edge (1-cycle latency); other channels SHALL hold.
REQ-025 clear_i SHALL have top priority: acc[ch_i] <= 0 and ovf_o[ch_i] <= 0, regardless of en_i or dump_i; no dump SHALL be issued.
REQ-026 dump_i SHALL be accepted when clear_i=0 and busy_o=0.
REQ-027 Accepted dump SHALL register result_o = acc[ch_i] (pre-update), result_ch_o = ch_i, result_ovf_o = ovf_o[ch_i], and assert result_valid_o on the next edge.
REQ-028 Accepted dump with en_i=1 SHALL load acc[ch_i] with sext(data_i) and set ovf_o[ch_i]=0; with en_i=0 it SHALL load 0.
REQ-029 Dump not accepted (busy_o=1) SHALL be dropped; en_i SHALL still accumulate normally.
REQ-030 result_valid_o SHALL remain high, with all result fields stable, until result_ready_i=1 at an edge; it then clears unless a new dump is accepted on that edge.
REQ-031 A dump accepted on the same edge as a handshake SHALL replace the output (back-to-back dumps, one per cycle).
REQ-032 ch_i >= NUM_CH SHALL make en_i, clear_i and dump_i no-ops.

Reset
REQ-033 rst_i=1 SHALL immediately set all acc to 0, ovf_o=0, result_o=0, result_ch_o=0, result_ovf_o=0, result_valid_o=0, regardless of clk.
REQ-034 Reset mid-dump or mid-handshake SHALL discard the pending result; first accepted dump after release SHALL report values accumulated after release only.

Verification
REQ-035 Defaults: en_i ch0 with 5, -3, 10; dump ch0 -> result_o=12, result_ch_o=0, result_ovf_o=0, valid next cycle; next dump of ch0 -> 0.
REQ-036 DIN_WIDTH=8, DOUT_WIDTH=10, SAT_EN=1: add 127 five times to ch1 -> acc=511, ovf_o[1]=1; dump -> 511, result_ovf_o=1; SAT_EN=0 same stimulus -> -389 (0x27B).
REQ-037 Same cycle clear_i+en_i+dump_i on ch2 holding 7 -> acc[2]=0, no result_valid_o; dump_i+en_i data 4 on ch2 holding 9 -> result 9, acc[2]=4.
REQ-038 result_ready_i=0 for 5 cycles after dump of ch0=3: result stable, busy_o=1, second dump of ch1 dropped, ch1 keeps accumulating; ready=1 with new dump same edge -> ch1 result next cycle.
REQ-039 Assert rst_i asynchronously between edges with result_valid_o=1 and non-zero channels -> all outputs 0 before next edge; ch_i=5 with NUM_CH=5 -> no state change.
